// File: rtl/countdown_timer.sv
// Microwave cook timer: BCD MM:SS keypad entry followed by a one-second-per-tick countdown
// that runs while the magnetron is enabled. timer_done feeds control_mag directly.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       enable,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [3:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       timer_done,
  output logic       done_pulse,
  output logic       running
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [DW-1:0] mt_nxt;
  logic [DW-1:0] mo_nxt;
  logic [DW-1:0] st_nxt;
  logic [DW-1:0] so_nxt;
  logic          done_nxt;
  logic          count_nz_c;
  logic          run_c;
  logic          tick_c;
  logic          entry_c;
  logic          nxt_zero_c;

  // Zero detect straight off the digit registers so control_mag sees it with no latency.
  assign timer_done = (mins_tens == '0) && (mins_ones == '0) &&
                      (secs_tens == '0) && (secs_ones == '0);
  assign running    = (state == RUN);

  // Next-state datapath: clear beats digit entry, which beats the tick decrement.
  always_comb begin
    mt_nxt     = mins_tens;
    mo_nxt     = mins_ones;
    st_nxt     = secs_tens;
    so_nxt     = secs_ones;
    presc_nxt  = presc;
    done_nxt   = 1'b0;
    state_nxt  = state;
    nxt_zero_c = 1'b0;

    count_nz_c = !timer_done;
    run_c      = count_nz_c && enable;
    tick_c     = run_c && (presc == PW'(TICK_DIV - 1));
    entry_c    = digit_valid && !enable && (digit <= 4'd9);

    if (!clearn) begin
      mt_nxt    = '0;
      mo_nxt    = '0;
      st_nxt    = '0;
      so_nxt    = '0;
      presc_nxt = '0;
    end else if (entry_c) begin
      mt_nxt = mins_ones;
      mo_nxt = secs_tens;
      st_nxt = secs_ones;
      so_nxt = digit;
    end else if (run_c) begin
      presc_nxt = tick_c ? '0 : presc + PW'(1);
      if (tick_c) begin
        // BCD borrow chain; secs_tens of 6..9 simply counts down, borrow reloads it with 5.
        if (secs_ones == '0) begin
          so_nxt = 4'd9;
          if (secs_tens == '0) begin
            st_nxt = 4'd5;
            if (mins_ones == '0) begin
              mo_nxt = 4'd9;
              mt_nxt = mins_tens - 4'd1;
            end else begin
              mo_nxt = mins_ones - 4'd1;
            end
          end else begin
            st_nxt = secs_tens - 4'd1;
          end
        end else begin
          so_nxt = secs_ones - 4'd1;
        end
      end
    end

    nxt_zero_c = (mt_nxt == '0) && (mo_nxt == '0) && (st_nxt == '0) && (so_nxt == '0);

    // A decrement that lands on 00:00 is the only source of done_pulse.
    if (clearn && tick_c && nxt_zero_c) begin
      done_nxt = 1'b1;
    end

    if (nxt_zero_c) begin
      state_nxt = IDLE;
      presc_nxt = '0;
    end else if (enable) begin
      state_nxt = RUN;
    end else begin
      state_nxt = LOADED;
    end
  end

  // State, prescaler, digits and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      presc      <= '0;
      mins_tens  <= '0;
      mins_ones  <= '0;
      secs_tens  <= '0;
      secs_ones  <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      mins_tens  <= mt_nxt;
      mins_ones  <= mo_nxt;
      secs_tens  <= st_nxt;
      secs_ones  <= so_nxt;
      done_pulse <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle tick.
module tb_countdown_timer;

  localparam int unsigned TICK_DIV = 4;

  logic       clk;
  logic       resetn;
  logic       clearn;
  logic       enable;
  logic       digit_valid;
  logic [3:0] digit;
  logic [3:0] mins_tens;
  logic [3:0] mins_ones;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       timer_done;
  logic       done_pulse;
  logic       running;

  int n_cmp;
  int n_bad;

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .clearn      (clearn),
    .enable      (enable),
    .digit_valid (digit_valid),
    .digit       (digit),
    .mins_tens   (mins_tens),
    .mins_ones   (mins_ones),
    .secs_tens   (secs_tens),
    .secs_ones   (secs_ones),
    .timer_done  (timer_done),
    .done_pulse  (done_pulse),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log any difference.
  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
  endtask

  function automatic logic [15:0] disp();
    return {mins_tens, mins_ones, secs_tens, secs_ones};
  endfunction

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    resetn      = 1'b0;
    clearn      = 1'b1;
    enable      = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;

    // 1: reset values
    step(3);
    resetn = 1'b1;
    step(1);
    check_eq("rst_disp",    disp(),              16'h0000);
    check_eq("rst_done",    16'(timer_done),     16'd1);
    check_eq("rst_running", 16'(running),        16'd0);
    check_eq("rst_pulse",   16'(done_pulse),     16'd0);

    // 2: digit entry, invalid digit ignored
    enter(4'd1);
    enter(4'd3);
    enter(4'd0);
    check_eq("load_0130",   disp(),              16'h0130);
    check_eq("load_done",   16'(timer_done),     16'd0);
    check_eq("load_run",    16'(running),        16'd0);
    enter(4'hA);
    check_eq("bad_digit",   disp(),              16'h0130);

    // 3: first tick after exactly 4 clocks, minute borrow
    enable = 1'b1;
    step(3);
    check_eq("pre_tick",    disp(),              16'h0130);
    check_eq("run_flag",    16'(running),        16'd1);
    step(1);
    check_eq("tick_0129",   disp(),              16'h0129);
    step(29 * TICK_DIV);
    check_eq("at_0100",     disp(),              16'h0100);
    step(TICK_DIV);
    check_eq("borrow_0059", disp(),              16'h0059);

    // 4: pause keeps sub-second phase
    step(14 * TICK_DIV);
    check_eq("at_0045",     disp(),              16'h0045);
    step(2);
    enable = 1'b0;
    step(10);
    check_eq("paused",      disp(),              16'h0045);
    check_eq("paused_run",  16'(running),        16'd0);
    enable = 1'b1;
    step(1);
    check_eq("resume_1",    disp(),              16'h0045);
    step(1);
    check_eq("resume_0044", disp(),              16'h0044);

    // 5: reach zero, single done pulse, no wrap with enable still high
    step(43 * TICK_DIV);
    check_eq("at_0001",     disp(),              16'h0001);
    check_eq("pulse_early", 16'(done_pulse),     16'd0);
    step(TICK_DIV);
    check_eq("zero",        disp(),              16'h0000);
    check_eq("zero_done",   16'(timer_done),     16'd1);
    check_eq("zero_pulse",  16'(done_pulse),     16'd1);
    check_eq("zero_run",    16'(running),        16'd0);
    step(1);
    check_eq("pulse_once",  16'(done_pulse),     16'd0);
    step(20);
    check_eq("stay_zero",   disp(),              16'h0000);
    check_eq("stay_pulse",  16'(done_pulse),     16'd0);

    // 6: unnormalised 90 s, digit dropped while running, clear, async reset
    enable = 1'b0;
    enter(4'd9);
    enter(4'd0);
    check_eq("load_0090",   disp(),              16'h0090);
    enable      = 1'b1;
    digit       = 4'd5;
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
    check_eq("drop_digit",  disp(),              16'h0090);
    step(3);
    check_eq("tick_0089",   disp(),              16'h0089);
    clearn      = 1'b0;
    digit       = 4'd7;
    digit_valid = 1'b1;
    step(1);
    clearn      = 1'b1;
    digit_valid = 1'b0;
    check_eq("clear",       disp(),              16'h0000);
    check_eq("clear_run",   16'(running),        16'd0);
    check_eq("clear_pulse", 16'(done_pulse),     16'd0);

    enable = 1'b0;
    enter(4'd1);
    enter(4'd2);
    enable = 1'b1;
    step(2);
    check_eq("pre_rst",     disp(),              16'h0012);
    check_eq("pre_rst_run", 16'(running),        16'd1);
    resetn = 1'b0;
    #2;
    check_eq("async_disp",  disp(),              16'h0000);
    check_eq("async_run",   16'(running),        16'd0);
    check_eq("async_done",  16'(timer_done),     16'd1);
    resetn = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
